// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing defaults, monitor FSM encoding and CRC constants
package vga_pkg;
  localparam int DEF_CLK_PER_PIX = 4;
  localparam int DEF_H_ACTIVE = 640, DEF_H_FP = 16, DEF_H_SYNC = 96, DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480, DEF_V_FP = 10, DEF_V_SYNC = 2, DEF_V_BP = 33;
  localparam int HT = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int VT = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int XSTART = (DEF_H_SYNC + DEF_H_BP) * DEF_CLK_PER_PIX;
  localparam int YSTART = DEF_V_SYNC + DEF_V_BP;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;
endpackage

// File: rtl/vga_crc16_step.sv
// vga_crc16_step: one CRC-16-CCITT update over 12 data bits, MSB first
module vga_crc16_step
  import vga_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [11:0] data,
  output logic [15:0] crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 11; i >= 0; i--)
      crc_out = {crc_out[14:0], 1'b0} ^ ((crc_out[15] ^ data[i]) ? CRC_POLY : 16'h0000);
  end
endmodule

// File: rtl/vga_capture_monitor.sv
// vga_capture_monitor: VGA sink that verifies sync timing, locks to the frame,
// rebuilds pixel coordinates and CRCs every active pixel of each locked frame
module vga_capture_monitor
  import vga_pkg::*;
#(
  parameter int CLK_PER_PIX = DEF_CLK_PER_PIX,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  input  logic        err_clr,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_done,
  output logic [15:0] frame_crc,
  output logic        h_err,
  output logic        v_err,
  output logic        blank_err
);
  localparam int CPP = CLK_PER_PIX;
  localparam logic [11:0] H_LAST = 12'((H_ACTIVE + H_FP + H_SYNC + H_BP) * CPP - 1);
  localparam logic [11:0] H_SW   = 12'(H_SYNC * CPP - 1);
  localparam logic [11:0] XS     = 12'((H_SYNC + H_BP) * CPP);
  localparam logic [11:0] XE     = 12'((H_SYNC + H_BP + H_ACTIVE) * CPP);
  localparam logic [9:0]  VTOT   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [9:0]  VSW    = 10'(V_SYNC);
  localparam logic [9:0]  YS     = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  YE     = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0]  X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_ACTIVE - 1);
  state_t state;
  logic hs_q, vs_q, h_as, h_de, v_as, v_de, chk, herr_now, verr_now, act, samp, cap, last;
  logic [11:0] rgb_q, hcnt, hoff;
  logic [9:0] vcnt, vnext, yoff, xn;
  logic [15:0] crc, crc_nxt;
  vga_crc16_step u_crc (.crc_in(crc), .data(rgb_q), .crc_out(crc_nxt));
  assign locked = state == LOCKED;
  // hcnt/vcnt are aligned with rgb_q; vnext includes a coincident hsync edge so
  // sync checks hold whether or not vsync moves together with hsync
  always_comb begin
    h_as = (hsync == SYNC_POL) && (hs_q != SYNC_POL);
    h_de = (hsync != SYNC_POL) && (hs_q == SYNC_POL);
    v_as = (vsync == SYNC_POL) && (vs_q != SYNC_POL);
    v_de = (vsync != SYNC_POL) && (vs_q == SYNC_POL);
    vnext = (h_as && vcnt != 10'h3FF) ? vcnt + 10'd1 : vcnt;
    chk = state != HUNT;
    herr_now = (hcnt == 12'hFFF) || (chk && ((h_as && hcnt != H_LAST) || (h_de && hcnt != H_SW)));
    verr_now = (vcnt == 10'h3FF) || (chk && ((v_as && vnext != VTOT) || (v_de && vnext != VSW)));
    hoff = hcnt - XS;
    yoff = vcnt - YS;
    xn = 10'(int'(hoff) / CPP);
    act = hcnt >= XS && hcnt < XE && vcnt >= YS && vcnt < YE;
    samp = act && (int'(hoff) % CPP == CPP / 2);
    last = samp && xn == X_LAST && yoff == Y_LAST;
    cap = locked && !herr_now && !verr_now;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hs_q <= ~SYNC_POL;
      vs_q <= ~SYNC_POL;
      rgb_q <= '0;
      hcnt <= '0;
      vcnt <= '0;
      crc <= CRC_INIT;
      state <= HUNT;
      pix_valid <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
      pix_rgb <= '0;
      frame_done <= 1'b0;
      frame_crc <= '0;
      h_err <= 1'b0;
      v_err <= 1'b0;
      blank_err <= 1'b0;
    end else begin
      hs_q <= hsync;
      vs_q <= vsync;
      rgb_q <= {r, g, b};
      hcnt <= h_as ? '0 : (hcnt == 12'hFFF) ? hcnt : hcnt + 12'd1;
      vcnt <= v_as ? '0 : vnext;
      crc <= v_as ? CRC_INIT : (cap && samp) ? crc_nxt : crc;
      pix_valid <= cap && samp;
      if (cap && samp) begin
        pix_x <= xn;
        pix_y <= yoff;
        pix_rgb <= rgb_q;
      end
      frame_done <= cap && last;
      if (cap && last) frame_crc <= crc_nxt;
      h_err <= herr_now || (h_err && !err_clr);
      v_err <= verr_now || (v_err && !err_clr);
      blank_err <= (locked && !act && |rgb_q) || (blank_err && !err_clr);
      if (herr_now || verr_now) state <= HUNT;
      else if (v_as) state <= (state == HUNT) ? TRACK : LOCKED;
    end
endmodule

// File: tb/tb_vga_capture_monitor.sv
// tb_vga_capture_monitor: directed frames on a shrunken raster exercising lock,
// capture, CRC, sync faults, blanking faults, reset and error clearing
module tb_vga_capture_monitor;
  localparam int CPP = 4, HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;
  localparam int F_NONE = 0, F_HSHORT = 1, F_VLONG = 2, F_BLANK = 3;
  logic clk = 1'b0, rst = 1'b1, hsync = 1'b1, vsync = 1'b1, err_clr = 1'b0;
  logic [3:0] r = '0, g = '0, b = '0;
  logic locked, pix_valid, frame_done, h_err, v_err, blank_err;
  logic [9:0] pix_x, pix_y;
  logic [11:0] pix_rgb;
  logic [15:0] frame_crc;
  int tests = 0, fails = 0, cmode = 0;
  int seq = 0, fx = -1, fy = -1, lx = -1, ly = -1, npix = 0, ndone = 0, nbad = 0, nsolo = 0, nvalid = 0;
  logic [15:0] dcrc = '0;

  vga_capture_monitor #(
    .CLK_PER_PIX(CPP), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b),
    .err_clr(err_clr), .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_rgb(pix_rgb), .frame_done(frame_done), .frame_crc(frame_crc),
    .h_err(h_err), .v_err(v_err), .blank_err(blank_err)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] colour(input int m, input int x, input int y);
    logic [3:0] xv, yv;
    xv = 4'(x);
    yv = 4'(y);
    return (m == 1) ? {xv, yv, 4'h0} : 12'hF00;
  endfunction

  function automatic logic [15:0] frame_model(input int m);
    logic [15:0] c;
    logic [11:0] d;
    c = 16'hFFFF;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++) begin
        d = colour(m, x, y);
        for (int i = 11; i >= 0; i--) begin
          if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
          else c = {c[14:0], 1'b0};
        end
      end
    return c;
  endfunction

  always @(negedge clk) begin
    if (!locked) seq = 0;
    if (pix_valid) begin
      if (seq == 0) begin
        fx = int'(pix_x);
        fy = int'(pix_y);
      end
      seq++;
      nvalid++;
      lx = int'(pix_x);
      ly = int'(pix_y);
      if (pix_rgb !== colour(cmode, int'(pix_x), int'(pix_y))) nbad++;
    end
    if (frame_done) begin
      ndone++;
      npix = seq;
      dcrc = frame_crc;
      if (!pix_valid) nsolo++;
      seq = 0;
    end
  end

  task automatic send_frame(input int fault);
    for (int l = 0; l < VT; l++) begin
      int hlen;
      hlen = (fault == F_HSHORT && l == 5) ? HT - 1 : HT;
      for (int p = 0; p < hlen; p++)
        for (int c = 0; c < CPP; c++) begin
          logic [11:0] px;
          @(negedge clk);
          hsync = p >= HS;
          vsync = l >= ((fault == F_VLONG) ? VS + 1 : VS);
          px = 12'h000;
          if (p >= HS + HB && p < HS + HB + HA && l >= VS + VB && l < VS + VB + VA)
            px = colour(cmode, p - HS - HB, l - VS - VB);
          else if (fault == F_BLANK && l == VS + VB && p == HS + HB + HA)
            px = 12'h001;
          {r, g, b} = px;
        end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++;
    if ({locked, pix_valid, frame_done, h_err, v_err, blank_err} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags got %b want 000000", {locked, pix_valid, frame_done, h_err, v_err, blank_err});
    end
    tests++;
    if ({pix_x, pix_y, pix_rgb} !== 32'h0) begin
      fails++;
      $display("FAIL reset_pix got x=%0d y=%0d rgb=%h want 0", pix_x, pix_y, pix_rgb);
    end
    tests++;
    if (frame_crc !== 16'h0) begin
      fails++;
      $display("FAIL reset_crc got %h want 0000", frame_crc);
    end
    rst = 1'b0;
  endtask

  task automatic test_lock_solid;
    int d0;
    cmode = 0;
    d0 = ndone;
    send_frame(F_NONE);
    tests++;
    if (locked !== 1'b0 || ndone != d0) begin
      fails++;
      $display("FAIL track_frame got locked=%b done=%0d want locked=0 done=0", locked, ndone - d0);
    end
    fork
      send_frame(F_NONE);
      begin
        @(negedge clk);
        tests++;
        if (locked !== 1'b0) begin
          fails++;
          $display("FAIL lock_before_edge got %b want 0", locked);
        end
        @(negedge clk);
        tests++;
        if (locked !== 1'b1) begin
          fails++;
          $display("FAIL lock_after_edge got %b want 1", locked);
        end
      end
    join
    tests++;
    if (ndone != d0 + 1 || npix != HA * VA) begin
      fails++;
      $display("FAIL solid_count got done=%0d pix=%0d want done=1 pix=%0d", ndone - d0, npix, HA * VA);
    end
    tests++;
    if (fx != 0 || fy != 0 || lx != HA - 1 || ly != VA - 1) begin
      fails++;
      $display("FAIL solid_coords got first=(%0d,%0d) last=(%0d,%0d) want (0,0) (%0d,%0d)", fx, fy, lx, ly, HA - 1, VA - 1);
    end
    tests++;
    if (dcrc !== frame_model(0)) begin
      fails++;
      $display("FAIL solid_crc got %h want %h", dcrc, frame_model(0));
    end
    tests++;
    if (nbad != 0 || nsolo != 0 || {h_err, v_err, blank_err} !== 3'b0) begin
      fails++;
      $display("FAIL solid_clean got bad=%0d solo=%0d flags=%b want 0 0 000", nbad, nsolo, {h_err, v_err, blank_err});
    end
  endtask

  task automatic test_gradient;
    int d0, b0;
    cmode = 1;
    d0 = ndone;
    b0 = nbad;
    send_frame(F_NONE);
    tests++;
    if (nbad != b0 || npix != HA * VA || ndone != d0 + 1) begin
      fails++;
      $display("FAIL grad_pixels got bad=%0d pix=%0d done=%0d want 0 %0d 1", nbad - b0, npix, ndone - d0, HA * VA);
    end
    tests++;
    if (dcrc !== frame_model(1)) begin
      fails++;
      $display("FAIL grad_crc got %h want %h", dcrc, frame_model(1));
    end
  endtask

  task automatic test_blank;
    int d0;
    cmode = 0;
    d0 = ndone;
    send_frame(F_BLANK);
    tests++;
    if ({blank_err, locked, h_err, v_err} !== 4'b1100) begin
      fails++;
      $display("FAIL blank_flags got blank,locked,h,v=%b want 1100", {blank_err, locked, h_err, v_err});
    end
    tests++;
    if (ndone != d0 + 1 || dcrc !== frame_model(0)) begin
      fails++;
      $display("FAIL blank_crc got done=%0d crc=%h want 1 %h", ndone - d0, dcrc, frame_model(0));
    end
  endtask

  task automatic test_err_clr;
    fork
      send_frame(F_NONE);
      begin
        repeat (11) @(negedge clk);
        tests++;
        if (blank_err !== 1'b1) begin
          fails++;
          $display("FAIL clr_before got %b want 1", blank_err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        tests++;
        if ({h_err, v_err, blank_err} !== 3'b0) begin
          fails++;
          $display("FAIL clr_after got %b want 000", {h_err, v_err, blank_err});
        end
      end
    join
    tests++;
    if ({locked, h_err, v_err, blank_err} !== 4'b1000) begin
      fails++;
      $display("FAIL clr_frame_end got %b want 1000", {locked, h_err, v_err, blank_err});
    end
  endtask

  task automatic relock(input string tag);
    int d0;
    d0 = ndone;
    send_frame(F_NONE);
    tests++;
    if (locked !== 1'b0 || ndone != d0) begin
      fails++;
      $display("FAIL %s_track got locked=%b done=%0d want 0 0", tag, locked, ndone - d0);
    end
    send_frame(F_NONE);
    tests++;
    if (locked !== 1'b1 || ndone != d0 + 1 || dcrc !== frame_model(cmode) || npix != HA * VA) begin
      fails++;
      $display("FAIL %s_relock got locked=%b done=%0d crc=%h pix=%0d want 1 1 %h %0d", tag, locked, ndone - d0, dcrc, npix, frame_model(cmode), HA * VA);
    end
  endtask

  task automatic test_hshort;
    int d0, v0;
    d0 = ndone;
    v0 = 0;
    fork
      send_frame(F_HSHORT);
      begin
        repeat (6 * HT * CPP - CPP + 1) @(negedge clk);
        tests++;
        if ({locked, h_err} !== 2'b10) begin
          fails++;
          $display("FAIL hshort_before got locked,h=%b want 10", {locked, h_err});
        end
        @(negedge clk);
        v0 = nvalid;
        tests++;
        if ({locked, h_err, v_err} !== 3'b010) begin
          fails++;
          $display("FAIL hshort_after got locked,h,v=%b want 010", {locked, h_err, v_err});
        end
      end
    join
    tests++;
    if (ndone != d0 || nvalid != v0 || frame_crc !== frame_model(0)) begin
      fails++;
      $display("FAIL hshort_discard got done=%0d late_valid=%0d crc=%h want 0 0 %h", ndone - d0, nvalid - v0, frame_crc, frame_model(0));
    end
    relock("hshort");
  endtask

  task automatic test_vlong;
    int d0;
    d0 = ndone;
    fork
      send_frame(F_VLONG);
      begin
        repeat (3 * HT * CPP + 1) @(negedge clk);
        tests++;
        if ({locked, v_err} !== 2'b10) begin
          fails++;
          $display("FAIL vlong_before got locked,v=%b want 10", {locked, v_err});
        end
        @(negedge clk);
        tests++;
        if ({locked, v_err} !== 2'b01) begin
          fails++;
          $display("FAIL vlong_after got locked,v=%b want 01", {locked, v_err});
        end
      end
    join
    tests++;
    if (ndone != d0 || frame_crc !== frame_model(0)) begin
      fails++;
      $display("FAIL vlong_discard got done=%0d crc=%h want 0 %h", ndone - d0, frame_crc, frame_model(0));
    end
    relock("vlong");
  endtask

  task automatic test_rst;
    int d0;
    d0 = ndone;
    fork
      send_frame(F_NONE);
      begin
        repeat (6 * HT * CPP + 51) @(negedge clk);
        tests++;
        if ({locked, h_err, v_err} !== 3'b111 || pix_y !== 10'd2) begin
          fails++;
          $display("FAIL rst_before got locked,h,v=%b y=%0d want 111 2", {locked, h_err, v_err}, pix_y);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({locked, pix_valid, pix_x, pix_y, pix_rgb, frame_done, frame_crc, h_err, v_err, blank_err} !== 54'h0) begin
          fails++;
          $display("FAIL rst_outputs got %h want 0", {locked, pix_valid, pix_x, pix_y, pix_rgb, frame_done, frame_crc, h_err, v_err, blank_err});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    tests++;
    if (ndone != d0 || locked !== 1'b0) begin
      fails++;
      $display("FAIL rst_frame got done=%0d locked=%b want 0 0", ndone - d0, locked);
    end
    relock("rst");
    tests++;
    if ({h_err, v_err, blank_err} !== 3'b0) begin
      fails++;
      $display("FAIL rst_flags got %b want 000", {h_err, v_err, blank_err});
    end
  endtask

  initial begin
    test_reset();
    test_lock_solid();
    test_gradient();
    test_blank();
    test_err_clr();
    test_hshort();
    test_vlong();
    test_rst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
